// File: rtl/fifo_if_pkg.sv
// Shared types and geometry helpers for the FIFO read-port consumers.
// Geometry is validated at elaboration so a bad width pairing never builds.
package fifo_if_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } unpack_state_t;

   function automatic int beats_f(input int in_w, input int out_w);
      return in_w / out_w;
   endfunction

   function automatic int idx_w_f(input int nbeats);
      return (nbeats > 1) ? $clog2(nbeats) : 1;
   endfunction

   function automatic bit geom_ok_f(input int in_w, input int out_w);
      return (out_w > 0) && ((in_w % out_w) == 0) && ((in_w / out_w) >= 2);
   endfunction

endpackage

// File: rtl/fifo_unpacker.sv
// Pops wide words from a FIFO read port and streams them as narrow beats,
// LSB slice first, with a last-beat marker and a completed-word counter.
module fifo_unpacker #(
   parameter int IN_WIDTH  = 32,
   parameter int OUT_WIDTH = 8,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 CLK,
   input  logic                 RST_N,
   input  logic                 CLR,
   input  logic                 EMPTY_N,
   input  logic [IN_WIDTH-1:0]  D_OUT,
   output logic                 DEQ,
   output logic                 OUT_VALID,
   input  logic                 OUT_READY,
   output logic [OUT_WIDTH-1:0] OUT_DATA,
   output logic                 OUT_LAST,
   output logic                 BUSY,
   output logic [CNT_WIDTH-1:0] WORD_CNT
);
   import fifo_if_pkg::*;

   localparam int NBEATS = beats_f(IN_WIDTH, OUT_WIDTH);
   localparam int IDX_W  = idx_w_f(NBEATS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBEATS - 1);

   generate
      if (!geom_ok_f(IN_WIDTH, OUT_WIDTH)) begin : g_bad_geom
         $error("fifo_unpacker: OUT_WIDTH must divide IN_WIDTH into at least 2 beats");
      end
   endgenerate

   unpack_state_t        state_q, state_d;
   logic [IN_WIDTH-1:0]  hold_q, hold_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                 acc, last_acc, deq;

   assign acc      = (state_q == SHIFT) & OUT_READY;
   assign last_acc = acc & (idx_q == LAST_IDX);
   // Popping is allowed only while idle or as the held word's final beat leaves.
   assign deq      = RST_N & EMPTY_N & ~CLR & ((state_q == IDLE) | last_acc);

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      if (CLR) begin
         state_d = IDLE;
         hold_d  = '0;
         idx_d   = '0;
         cnt_d   = '0;
      end else begin
         if (last_acc) begin
            cnt_d   = cnt_q + 1'b1;
            state_d = IDLE;
            hold_d  = '0;
            idx_d   = '0;
         end else if (acc) begin
            hold_d = hold_q >> OUT_WIDTH;
            idx_d  = idx_q + 1'b1;
         end
         // A pop in the final-beat cycle overrides the return to idle.
         if (deq) begin
            state_d = SHIFT;
            hold_d  = D_OUT;
            idx_d   = '0;
         end
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= IDLE;
         hold_q  <= '0;
         idx_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
      end
   end

   assign DEQ       = deq;
   assign OUT_VALID = (state_q == SHIFT);
   assign OUT_DATA  = hold_q[OUT_WIDTH-1:0];
   assign OUT_LAST  = (idx_q == LAST_IDX);
   assign BUSY      = (state_q == SHIFT);
   assign WORD_CNT  = cnt_q;

endmodule
